// File: rtl/hxm_pkg.sv
// hxm_pkg: shared widths, FIFO entry layout, FSM states and helpers for hxm_read_unpacker
package hxm_pkg;
    localparam int SSIDBITS = 8;
    localparam int HITINFOBITS = 8;
    localparam int MAXHITS = 4;
    localparam int MAXHITNBITS = 3;
    localparam int HITWORDBITS = MAXHITS * HITINFOBITS;

    typedef struct packed {
        logic [SSIDBITS-1:0] ssid;
        logic empty;
        logic [MAXHITNBITS-1:0] count;
        logic [HITWORDBITS-1:0] hitInfo;
    } hxmEntry_t;

    typedef enum logic {IDLE, EMIT} hxmState_t;

    function automatic logic [HITINFOBITS-1:0] slotInfo(input logic [HITWORDBITS-1:0] hitInfo, input logic [MAXHITNBITS-1:0] idx);
        return hitInfo[idx*HITINFOBITS +: HITINFOBITS];
    endfunction

    function automatic logic [MAXHITNBITS-1:0] clampCount(input logic [MAXHITNBITS-1:0] n);
        return (n > MAXHITNBITS'(MAXHITS)) ? MAXHITNBITS'(MAXHITS) : n;
    endfunction
endpackage

// File: rtl/hxm_resp_fifo.sv
// hxm_resp_fifo: synchronous response FIFO; a push into a full FIFO succeeds when a pop happens the same cycle
module hxm_resp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wrData,
    output logic [WIDTH-1:0]         rdData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic doPush, doPop;

    assign empty = count == '0;
    assign full = count == (AW+1)'(DEPTH);
    assign doPop = pop && !empty;
    assign doPush = push && (!full || doPop);
    assign rdData = mem[rdPtr];

    always_ff @(posedge clk)
        if (doPush) mem[wrPtr] <= wrData;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            wrPtr <= doPush ? wrPtr + AW'(1) : wrPtr;
            rdPtr <= doPop ? rdPtr + AW'(1) : rdPtr;
            count <= count + (AW+1)'(doPush) - (AW+1)'(doPop);
        end
endmodule

// File: rtl/hxm_read_unpacker.sv
// hxm_read_unpacker: buffers hxmpp read responses and serialises them into one-hit-per-beat records.
// Optional HXM_EMPTY_RECORD_EN: hit-less responses are queued and emit a single out_empty record.
module hxm_read_unpacker
    import hxm_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              resp_valid,
    input  logic [SSIDBITS-1:0]               resp_ssid,
    input  logic                              resp_hit,
    input  logic [MAXHITNBITS-1:0]            resp_nhits,
    input  logic [HITWORDBITS-1:0]            resp_hitinfo,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [SSIDBITS-1:0]               out_ssid,
    output logic [HITINFOBITS-1:0]            out_info,
    output logic [MAXHITNBITS-1:0]            out_idx,
    output logic                              out_last,
    output logic                              out_empty,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_count,
    output logic                              overflow,
    output logic                              truncated
);
    hxmEntry_t wrEntry, rdEntry;
    hxmState_t state;
    logic hasHits, pushReq, popReq, fifoFull, fifoEmpty;
    logic [HITWORDBITS-1:0] holdInfo;
    logic [MAXHITNBITS-1:0] holdCount, nextIdx;

    assign hasHits = resp_hit && resp_nhits != '0;
`ifdef HXM_EMPTY_RECORD_EN
    assign pushReq = resp_valid;
    assign wrEntry = '{ssid: resp_ssid, empty: !hasHits,
                       count: hasHits ? clampCount(resp_nhits) : MAXHITNBITS'(1),
                       hitInfo: hasHits ? resp_hitinfo : '0};
`else
    assign pushReq = resp_valid && hasHits;
    assign wrEntry = '{ssid: resp_ssid, empty: 1'b0, count: clampCount(resp_nhits), hitInfo: resp_hitinfo};
`endif

    // out_last is only meaningful in EMIT; in IDLE any non-empty FIFO triggers a pop
    assign popReq = !fifoEmpty && (state == IDLE || (out_ready && out_last));
    assign nextIdx = out_idx + MAXHITNBITS'(1);

    hxm_resp_fifo #(
        .WIDTH($bits(hxmEntry_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk(clk),
        .reset_n(reset_n),
        .push(pushReq),
        .pop(popReq),
        .wrData(wrEntry),
        .rdData(rdEntry),
        .full(fifoFull),
        .empty(fifoEmpty),
        .count(fifo_count)
    );

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            overflow <= 1'b0;
            truncated <= 1'b0;
        end else begin
            if (pushReq && fifoFull && !popReq) overflow <= 1'b1;
            if (resp_valid && hasHits && resp_nhits > MAXHITNBITS'(MAXHITS)) truncated <= 1'b1;
        end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state <= IDLE;
            holdInfo <= '0;
            holdCount <= '0;
            out_valid <= 1'b0;
            out_ssid <= '0;
            out_info <= '0;
            out_idx <= '0;
            out_last <= 1'b0;
            out_empty <= 1'b0;
        end else if (popReq) begin
            state <= EMIT;
            holdInfo <= rdEntry.hitInfo;
            holdCount <= rdEntry.count;
            out_valid <= 1'b1;
            out_ssid <= rdEntry.ssid;
            out_info <= slotInfo(rdEntry.hitInfo, '0);
            out_idx <= '0;
            out_last <= rdEntry.count == MAXHITNBITS'(1);
            out_empty <= rdEntry.empty;
        end else if (state == EMIT && out_ready) begin
            if (out_last) begin
                state <= IDLE;
                out_valid <= 1'b0;
            end else begin
                out_idx <= nextIdx;
                out_info <= slotInfo(holdInfo, nextIdx);
                out_last <= nextIdx == holdCount - MAXHITNBITS'(1);
            end
        end
endmodule

// File: tb/tb_hxm_read_unpacker.sv
// tb_hxm_read_unpacker: scoreboard bench with directed and randomized responses against a record-list model
module tb_hxm_read_unpacker;
    import hxm_pkg::*;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic resp_valid = 1'b0;
    logic [7:0] resp_ssid = '0;
    logic resp_hit = 1'b0;
    logic [2:0] resp_nhits = '0;
    logic [31:0] resp_hitinfo = '0;
    logic out_valid, out_last, out_empty, overflow, truncated;
    logic out_ready = 1'b0;
    logic [7:0] out_ssid, out_info;
    logic [2:0] out_idx;
    logic [2:0] fifo_count;

    logic [20:0] expQ[$];
    int nChecks = 0;
    int nFails = 0;
    int issued = 0;
    int done = 0;

    always #5 clk = ~clk;

    hxm_read_unpacker #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .resp_valid(resp_valid), .resp_ssid(resp_ssid), .resp_hit(resp_hit),
        .resp_nhits(resp_nhits), .resp_hitinfo(resp_hitinfo),
        .out_valid(out_valid), .out_ready(out_ready), .out_ssid(out_ssid),
        .out_info(out_info), .out_idx(out_idx), .out_last(out_last),
        .out_empty(out_empty), .fifo_count(fifo_count),
        .overflow(overflow), .truncated(truncated)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int modelPush(input logic [7:0] ssid, input logic hit, input logic [2:0] nhits, input logic [31:0] info);
        int n = (nhits > 3'd4) ? 4 : int'(nhits);
        if (hit && nhits != 0) begin
            for (int k = 0; k < n; k++)
                expQ.push_back({ssid, info[k*8 +: 8], 3'(k), k == n - 1, 1'b0});
            return 1;
        end
`ifdef HXM_EMPTY_RECORD_EN
        expQ.push_back({ssid, 8'h00, 3'd0, 1'b1, 1'b1});
        return 1;
`else
        return 0;
`endif
    endfunction

    task automatic sendResp(input logic [7:0] ssid, input logic hit, input logic [2:0] nhits, input logic [31:0] info, input bit accept);
        resp_valid = 1'b1;
        resp_ssid = ssid;
        resp_hit = hit;
        resp_nhits = nhits;
        resp_hitinfo = info;
        if (accept) issued += modelPush(ssid, hit, nhits, info);
        @(posedge clk);
        #1;
        resp_valid = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic waitValid(input string name);
        int n = 0;
        while (!out_valid && n < 20) begin
            cycle();
            n++;
        end
        check(name, out_valid, 1);
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while ((expQ.size() != 0 || out_valid) && n < 300) begin
            cycle();
            n++;
        end
        check(name, expQ.size(), 0);
    endtask

    initial forever begin
        logic [20:0] exp;
        @(negedge clk);
        if (reset_n && out_valid && out_ready) begin
            if (expQ.size() == 0) check("spurious_record", expQ.size(), 1);
            else begin
                exp = expQ.pop_front();
                check("record", {out_ssid, out_info, out_idx, out_last, out_empty}, exp);
                if (out_last) done++;
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_count", fifo_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_truncated", truncated, 0);
        reset_n = 1'b1;
        cycle();

        out_ready = 1'b1;
        sendResp(8'h48, 1'b1, 3'd3, 32'h0047_4048, 1'b1);
        check("basic_n1_valid", out_valid, 0);
        cycle();
        check("basic_n2_valid", out_valid, 1);
        check("basic_n2_idx", out_idx, 0);
        check("basic_n2_ssid", out_ssid, 8'h48);
        waitDrain("basic_drain");
        check("basic_idle", out_valid, 0);

        out_ready = 1'b0;
        sendResp(8'h48, 1'b1, 3'd3, 32'h0047_4048, 1'b1);
        waitValid("bp_valid");
        for (int i = 0; i < 5; i++) begin
            check("bp_info_stable", out_info, 8'h48);
            check("bp_idx_stable", out_idx, 0);
            cycle();
        end
        out_ready = 1'b1;
        waitDrain("bp_drain");

        out_ready = 1'b0;
        check("ovf_before", overflow, 0);
        for (int i = 0; i < 6; i++)
            sendResp(8'h10 + 8'(i), 1'b1, 3'd1, 32'hA0 + 32'(i), i < 5);
        check("ovf_flag", overflow, 1);
        check("ovf_count", fifo_count, 4);
        check("ovf_head_ssid", out_ssid, 8'h10);
        out_ready = 1'b1;
        waitDrain("ovf_drain");

        check("trunc_before", truncated, 0);
        sendResp(8'h5C, 1'b1, 3'd7, 32'h1357_9BDF, 1'b1);
        waitDrain("trunc_drain");
        check("trunc_flag", truncated, 1);

        sendResp(8'h2B, 1'b0, 3'd0, 32'h0, 1'b1);
`ifdef HXM_EMPTY_RECORD_EN
        check("empty_count", fifo_count, 1);
`else
        check("empty_count", fifo_count, 0);
`endif
        waitDrain("empty_drain");

        for (int c = 0; c < 400; c++) begin
            out_ready = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 2) == 0 && issued - done < DEPTH)
                sendResp(8'($urandom), $urandom_range(0, 4) != 0, 3'($urandom_range(0, 7)), $urandom, 1'b1);
            else
                cycle();
        end
        out_ready = 1'b1;
        waitDrain("rand_drain");

        out_ready = 1'b0;
        sendResp(8'h33, 1'b1, 3'd3, 32'h0099_8877, 1'b1);
        waitValid("rstmid_valid");
        reset_n = 1'b0;
        expQ.delete();
        issued = done;
        cycle();
        check("rstmid_valid_low", out_valid, 0);
        check("rstmid_count", fifo_count, 0);
        check("rstmid_overflow", overflow, 0);
        check("rstmid_truncated", truncated, 0);
        reset_n = 1'b1;
        out_ready = 1'b1;
        repeat (10) cycle();
        check("rstmid_quiet", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
